// File: rtl/cd_spi_slave_if.sv
// SPI pins and CDBUS CSR port bundled for the cd_spi_slave bridge.
// The slave modport is the bridge's view; master is the MCU/controller side.
interface cd_spi_slave_if;
  logic       sclk;
  logic       mosi;
  logic       nss;
  logic       miso;
  logic       miso_oe;
  logic       chip_select;
  logic [4:0] csr_address;
  logic       csr_read;
  logic [7:0] csr_readdata;
  logic       csr_write;
  logic [7:0] csr_writedata;

  modport slave (
    input  sclk, mosi, nss, csr_readdata,
    output miso, miso_oe, chip_select, csr_address, csr_read, csr_write, csr_writedata
  );

  modport master (
    output sclk, mosi, nss, csr_readdata,
    input  miso, miso_oe, chip_select, csr_address, csr_read, csr_write, csr_writedata
  );
endinterface

// File: rtl/cd_spi_slave.sv
// SPI mode-0 slave that turns command/data frames into single-cycle CDBUS CSR strobes.
// Byte 0 carries R/W and address; following bytes burst to or from that address.
module cd_spi_slave #(
  parameter int unsigned SYNC_LEN = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  cd_spi_slave_if.slave   bus
);

  typedef enum logic [1:0] {StWaitIdle, StIdle, StCmd, StData} state_e;

  state_e               state_q, state_d;
  logic [SYNC_LEN-1:0]  sclk_sync_q, mosi_sync_q, nss_sync_q;
  logic                 sclk_prev_q, nss_prev_q;
  logic [2:0]           cnt_q, cnt_d;
  logic [6:0]           rx_q, rx_d;
  logic [7:0]           tx_q, tx_d;
  logic                 skip_q, skip_d;
  logic                 load_q, load_d;
  logic                 wr_mode_q, wr_mode_d;
  logic [4:0]           addr_q, addr_d;
  logic                 rd_q, rd_d;
  logic                 wr_q, wr_d;
  logic [7:0]           wdata_q, wdata_d;

  logic       sclk_s, mosi_s, nss_s;
  logic       rise, fall, nss_fall;
  logic [7:0] byte_in;

  assign sclk_s   = sclk_sync_q[SYNC_LEN-1];
  assign mosi_s   = mosi_sync_q[SYNC_LEN-1];
  assign nss_s    = nss_sync_q[SYNC_LEN-1];
  assign rise     = sclk_s & ~sclk_prev_q;
  assign fall     = ~sclk_s & sclk_prev_q;
  assign nss_fall = ~nss_s & nss_prev_q;
  assign byte_in  = {rx_q, mosi_s};

  // nss synchroniser resets low so a frame already running at reset release is not
  // mistaken for an idle bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      nss_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      nss_prev_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_LEN-2:0], bus.sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_LEN-2:0], bus.mosi};
      nss_sync_q  <= {nss_sync_q[SYNC_LEN-2:0], bus.nss};
      sclk_prev_q <= sclk_s;
      nss_prev_q  <= nss_s;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StWaitIdle;
      cnt_q     <= 3'd0;
      rx_q      <= 7'd0;
      tx_q      <= 8'd0;
      skip_q    <= 1'b0;
      load_q    <= 1'b0;
      wr_mode_q <= 1'b0;
      addr_q    <= 5'd0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      skip_q    <= skip_d;
      load_q    <= load_d;
      wr_mode_q <= wr_mode_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    skip_d    = skip_q;
    wr_mode_d = wr_mode_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    load_d    = rd_q;

    // The first fall after a load must not shift: bit7 is already on miso for the next rise.
    if (load_q) begin
      tx_d   = bus.csr_readdata;
      skip_d = 1'b1;
    end else if (fall) begin
      if (skip_q) skip_d = 1'b0;
      else        tx_d   = {tx_q[6:0], 1'b0};
    end

    case (state_q)
      StWaitIdle: if (nss_s) state_d = StIdle;
      StIdle: begin
        if (nss_fall) begin
          state_d = StCmd;
          cnt_d   = 3'd0;
          rx_d    = 7'd0;
          tx_d    = 8'd0;
          skip_d  = 1'b0;
        end
      end
      StCmd: begin
        if (rise) begin
          cnt_d = cnt_q + 3'd1;
          rx_d  = byte_in[6:0];
          if (cnt_q == 3'd7) begin
            addr_d    = byte_in[4:0];
            wr_mode_d = byte_in[7];
            rd_d      = ~byte_in[7];
            state_d   = StData;
          end
        end
      end
      StData: begin
        if (rise) begin
          cnt_d = cnt_q + 3'd1;
          rx_d  = byte_in[6:0];
          if (cnt_q == 3'd7) begin
            if (wr_mode_q) begin
              wr_d    = 1'b1;
              wdata_d = byte_in;
            end else begin
              rd_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StWaitIdle;
    endcase

    // Strobes decided above still fire when nss rises on the 8th edge.
    if ((state_q == StCmd || state_q == StData) && nss_s) state_d = StIdle;
  end

  assign bus.chip_select   = (state_q != StWaitIdle) & ~nss_s;
  assign bus.miso_oe       = bus.chip_select;
  assign bus.miso          = tx_q[7];
  assign bus.csr_address   = addr_q;
  assign bus.csr_read      = rd_q;
  assign bus.csr_write     = wr_q;
  assign bus.csr_writedata = wdata_q;

endmodule

// File: tb/tb_cd_spi_slave.sv
// Directed bench for cd_spi_slave: SPI master tasks, a small CSR responder and strobe logger.
module tb_cd_spi_slave;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;
  int   cyc;

  cd_spi_slave_if bus ();

  cd_spi_slave #(.SYNC_LEN(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR responder and strobe logger
  logic [7:0] rd_tab [4];
  int         rd_base;
  int         rd_total, wr_total, wr_cyc;
  int         excl_err, wide_err;
  logic [4:0] wr_addr_log [16];
  logic [7:0] wr_data_log [16];
  logic [4:0] rd_addr_log [16];
  logic       prev_rd, prev_wr;

  initial begin
    cyc = 0; rd_total = 0; wr_total = 0; wr_cyc = 0;
    excl_err = 0; wide_err = 0; prev_rd = 1'b0; prev_wr = 1'b0;
  end

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    prev_rd <= bus.csr_read;
    prev_wr <= bus.csr_write;
    if (bus.csr_read && bus.csr_write) excl_err <= excl_err + 1;
    if ((bus.csr_read && prev_rd) || (bus.csr_write && prev_wr)) wide_err <= wide_err + 1;
    if (bus.csr_read) begin
      bus.csr_readdata                <= rd_tab[(rd_total - rd_base) & 3];
      rd_addr_log[rd_total[3:0]]      <= bus.csr_address;
      rd_total                        <= rd_total + 1;
    end
    if (bus.csr_write) begin
      wr_addr_log[wr_total[3:0]] <= bus.csr_address;
      wr_data_log[wr_total[3:0]] <= bus.csr_writedata;
      wr_total                   <= wr_total + 1;
      wr_cyc                     <= cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int hi_t, lo_t, last_rise_cyc;

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = tx[7-i];
      repeat (lo_t) @(negedge clk);
      bus.sclk = 1'b1;
      rx = {rx[6:0], bus.miso};
      if (i == 7) last_rise_cyc = cyc;
      repeat (hi_t) @(negedge clk);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic frame_end(input int gap);
    repeat (4) @(negedge clk);
    bus.nss = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  int         w0, r0;
  logic [7:0] rxv, rxa, rxb;

  initial begin
    n_cmp = 0; n_err = 0;
    hi_t = 5; lo_t = 5; rd_base = 0;
    for (int i = 0; i < 4; i++) rd_tab[i] = 8'h00;
    bus.nss = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_miso", {31'd0, bus.miso}, 32'd0);
    check_eq("rst_oe", {31'd0, bus.miso_oe}, 32'd0);
    check_eq("rst_cs", {31'd0, bus.chip_select}, 32'd0);
    check_eq("rst_addr", {27'd0, bus.csr_address}, 32'd0);
    check_eq("rst_rd", {31'd0, bus.csr_read}, 32'd0);
    check_eq("rst_wr", {31'd0, bus.csr_write}, 32'd0);
    check_eq("rst_wdata", {24'd0, bus.csr_writedata}, 32'd0);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);

    // Write burst 0x83, 0x11, 0x22
    w0 = wr_total; r0 = rd_total;
    bus.nss = 1'b0;
    spi_xfer(8'h83, 8, rxv);
    spi_xfer(8'h11, 8, rxv);
    check_eq("wr_latency", wr_cyc - last_rise_cyc, 32'd3);
    check_eq("wr_miso0", {24'd0, rxv}, 32'h00);
    spi_xfer(8'h22, 8, rxv);
    frame_end(6);
    check_eq("wr_count", wr_total - w0, 32'd2);
    check_eq("wr_addr0", {27'd0, wr_addr_log[w0[3:0]]}, 32'd3);
    check_eq("wr_data0", {24'd0, wr_data_log[w0[3:0]]}, 32'h11);
    check_eq("wr_addr1", {27'd0, wr_addr_log[w0[3:0]+4'd1]}, 32'd3);
    check_eq("wr_data1", {24'd0, wr_data_log[w0[3:0]+4'd1]}, 32'h22);
    check_eq("wr_no_read", rd_total - r0, 32'd0);

    // Read burst 0x05 + 2 dummies
    rd_base = rd_total; r0 = rd_total; w0 = wr_total;
    rd_tab[0] = 8'hA5; rd_tab[1] = 8'h3C; rd_tab[2] = 8'h99;
    bus.nss = 1'b0;
    spi_xfer(8'h05, 8, rxv);
    check_eq("rd_cs", {31'd0, bus.chip_select}, 32'd1);
    check_eq("rd_oe", {31'd0, bus.miso_oe}, 32'd1);
    spi_xfer(8'h00, 8, rxa);
    spi_xfer(8'h00, 8, rxb);
    frame_end(6);
    check_eq("rd_byte0", {24'd0, rxa}, 32'hA5);
    check_eq("rd_byte1", {24'd0, rxb}, 32'h3C);
    check_eq("rd_count", rd_total - r0, 32'd3);
    for (int i = 0; i < 3; i++)
      check_eq("rd_addr", {27'd0, rd_addr_log[r0[3:0]+i[3:0]]}, 32'd5);
    check_eq("rd_no_write", wr_total - w0, 32'd0);
    check_eq("idle_cs", {31'd0, bus.chip_select}, 32'd0);

    // Abort mid-byte on write to address 1, then a clean frame
    w0 = wr_total;
    bus.nss = 1'b0;
    spi_xfer(8'h81, 8, rxv);
    spi_xfer(8'h55, 8, rxv);
    spi_xfer(8'h66, 4, rxv);
    frame_end(6);
    check_eq("abort_count", wr_total - w0, 32'd1);
    check_eq("abort_addr", {27'd0, wr_addr_log[w0[3:0]]}, 32'd1);
    check_eq("abort_data", {24'd0, wr_data_log[w0[3:0]]}, 32'h55);
    w0 = wr_total;
    bus.nss = 1'b0;
    spi_xfer(8'h84, 8, rxv);
    spi_xfer(8'h9A, 8, rxv);
    frame_end(6);
    check_eq("post_abort_count", wr_total - w0, 32'd1);
    check_eq("post_abort_addr", {27'd0, wr_addr_log[w0[3:0]]}, 32'd4);
    check_eq("post_abort_data", {24'd0, wr_data_log[w0[3:0]]}, 32'h9A);

    // Reset pulsed mid data byte with nss held low
    bus.nss = 1'b0;
    spi_xfer(8'h83, 8, rxv);
    spi_xfer(8'h11, 8, rxv);
    spi_xfer(8'h22, 3, rxv);
    reset_n = 1'b0;
    #2;
    check_eq("mrst_cs", {31'd0, bus.chip_select}, 32'd0);
    check_eq("mrst_addr", {27'd0, bus.csr_address}, 32'd0);
    check_eq("mrst_wdata", {24'd0, bus.csr_writedata}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    w0 = wr_total; r0 = rd_total;
    spi_xfer(8'hFF, 8, rxv);
    spi_xfer(8'h00, 8, rxv);
    check_eq("mrst_cs_wait", {31'd0, bus.chip_select}, 32'd0);
    frame_end(6);
    check_eq("mrst_no_wr", wr_total - w0, 32'd0);
    check_eq("mrst_no_rd", rd_total - r0, 32'd0);
    bus.nss = 1'b0;
    spi_xfer(8'h82, 8, rxv);
    spi_xfer(8'h7E, 8, rxv);
    frame_end(6);
    check_eq("mrst_count", wr_total - w0, 32'd1);
    check_eq("mrst_addr2", {27'd0, wr_addr_log[w0[3:0]]}, 32'd2);
    check_eq("mrst_data", {24'd0, wr_data_log[w0[3:0]]}, 32'h7E);

    // Minimum timing read of address 0
    hi_t = 4; lo_t = 4;
    rd_base = rd_total; r0 = rd_total;
    rd_tab[0] = 8'hFF; rd_tab[1] = 8'hFF;
    bus.nss = 1'b0;
    spi_xfer(8'h00, 8, rxv);
    spi_xfer(8'h00, 8, rxa);
    frame_end(4);
    check_eq("min_byte", {24'd0, rxa}, 32'hFF);
    check_eq("min_rd_addr", {27'd0, rd_addr_log[r0[3:0]]}, 32'd0);

    // Back-to-back frames with a 4-cycle nss gap
    w0 = wr_total;
    bus.nss = 1'b0;
    spi_xfer(8'h87, 8, rxv);
    spi_xfer(8'h12, 8, rxv);
    frame_end(0);
    repeat (3) @(negedge clk);
    check_eq("b2b_cs_gap", {31'd0, bus.chip_select}, 32'd0);
    @(negedge clk);
    bus.nss = 1'b0;
    spi_xfer(8'h88, 8, rxv);
    spi_xfer(8'h34, 8, rxv);
    frame_end(6);
    check_eq("b2b_count", wr_total - w0, 32'd2);
    check_eq("b2b_addr0", {27'd0, wr_addr_log[w0[3:0]]}, 32'd7);
    check_eq("b2b_data0", {24'd0, wr_data_log[w0[3:0]]}, 32'h12);
    check_eq("b2b_addr1", {27'd0, wr_addr_log[w0[3:0]+4'd1]}, 32'd8);
    check_eq("b2b_data1", {24'd0, wr_data_log[w0[3:0]+4'd1]}, 32'h34);

    check_eq("strobe_excl", excl_err, 32'd0);
    check_eq("strobe_width", wide_err, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cd_spi_slave.md
# cd_spi_slave

SPI-slave front end that feeds the CDBUS controller's 8-bit CSR port, letting an external MCU reach all 32 CDBUS registers over a 4-wire SPI link. It synchronises the SPI pins into `clk`, decodes a command byte, and issues single-cycle `csr_read` / `csr_write` strobes into the controller. It also drives the controller's `chip_select` so RX-RAM read power is spent only during a transaction. SPI mode 0 only: CPOL=0, CPHA=0, MSB first.

## Interface
- `SYNC_LEN`, default 2: synchroniser depth for `sclk`, `mosi` and `nss`; legal values 2–3.
- `clk`  in  1  system clock; same clock as the CDBUS controller.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sclk`  in  1  SPI clock from the master; asynchronous to `clk`.
- `mosi`  in  1  SPI data from the master; asynchronous to `clk`.
- `nss`  in  1  SPI slave select, active low; asynchronous to `clk`.
- `miso`  out  1  SPI data to the master.
- `miso_oe`  out  1  output enable for the `miso` pad buffer.
- `chip_select`  out  1  high while a transaction is active; drives the controller's `chip_select`.
- `csr_address`  out  5  CSR register address.
- `csr_read`  out  1  one-cycle read strobe.
- `csr_readdata`  in  8  CSR read data; valid in the cycle after `csr_read`.
- `csr_write`  out  1  one-cycle write strobe.
- `csr_writedata`  out  8  CSR write data; valid while `csr_write` is high.

## Operation
- **Synchronisers.** `sclk`, `mosi` and `nss` each pass through `SYNC_LEN` flops.
  - `rise` is the registered 0→1 edge of synchronised `sclk`; `fall` is the 1→0 edge.
- **Frame format.** Each frame is delimited by `nss` low.
  - Byte 0 is the command: bit7 = R/W (1 = write), bits6:5 ignored, bits4:0 = address.
  - Every following byte is data to or from that same address. The address does not auto-increment, so burst access to the RX/TX data ports works.
- **States:** `WAIT_IDLE`, `IDLE`, `CMD`, `DATA`.
  - `WAIT_IDLE` is the reset state. It moves to `IDLE` once synchronised `nss` is seen high, so a frame that was already in progress at reset release is ignored.
  - `IDLE` → `CMD` on synchronised `nss` falling. The bit counter and shift registers clear; the TX shift register loads 0x00.
  - `CMD`: on each `rise`, shift `mosi` in. On the 8th `rise`:
    - latch the address and R/W bit, then go to `DATA`;
    - if R/W = 0, pulse `csr_read` in the same cycle.
  - `DATA`: on each `rise`, shift `mosi` in. On the 8th `rise` of each byte:
    - write: pulse `csr_write`, with `csr_writedata` = the assembled byte;
    - read: pulse `csr_read` to prefetch the next byte.
  - Any state → `IDLE` when synchronised `nss` rises. A partial byte is discarded and no strobe is issued for it.
- **Read data path.**
  - `csr_readdata` is captured into the TX shift register in the cycle after `csr_read`.
  - `miso` = TX shift register bit7. The register shifts left on each `fall`, except the `fall` that follows a load.
  - Reads always prefetch, so one surplus `csr_read` occurs after the last byte of every read burst. This is accepted: the controller's data-port pointers are reset by its frame-done/clear commands.
- **Write bursts.** `miso` outputs 0x00 throughout.
- **`chip_select`** = inverse of synchronised `nss`, held low in `WAIT_IDLE`.
- **`miso_oe`** equals `chip_select`.
- **Strobe exclusivity.** `csr_read` and `csr_write` are never high in the same cycle. `csr_address` holds its value between frames.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `chip_select`=0, `csr_address`=0, `csr_read`=0, `csr_write`=0, `csr_writedata`=0.
- Pin-to-strobe latency: the strobe is asserted `SYNC_LEN`+1 `clk` cycles after the 8th `sclk` pin rising edge. It is exactly 1 cycle wide.
- Master constraints, all in `clk` periods:
  - `sclk` high ≥ 4 and low ≥ 4;
  - `nss` falling to first `sclk` rise ≥ 4;
  - last `sclk` fall to `nss` rise ≥ 4;
  - `nss` high time between frames ≥ 4.
- Read turnaround: with `SYNC_LEN`=2, `csr_readdata` is loaded 4 cycles after the 8th pin edge. This is before the next `fall`, guaranteed by the high-time constraint.
- `nss` rise in the same cycle as an 8th `rise`: the strobe is still issued, then the block goes to `IDLE`.
- `reset_n` asserted mid-frame: all outputs return to reset values asynchronously, and the block waits in `WAIT_IDLE` for `nss` high.

## Test plan
- **Write burst:** frame 0x83, 0x11, 0x22 → `csr_write` pulses twice at address 3 with data 0x11, then 0x22; no `csr_read`.
- **Read burst:** frame 0x05 plus 2 dummy bytes, with CSR model returning 0xA5 then 0x3C → `miso` shows 0xA5, 0x3C; `csr_read` pulses 3 times, all at address 5.
- **Abort:** `nss` rises after 4 bits of the 2nd data byte of a write to address 1 → exactly one `csr_write`; state back to `IDLE`; the next frame decodes correctly.
- **Reset mid-frame:** `reset_n` pulsed during a data byte with `nss` held low → no strobes until `nss` goes high and then low again; the following frame 0x82, 0x7E writes 0x7E to address 2.
- **Minimum timing:** `sclk` at 4/4-cycle high/low, `SYNC_LEN`=2, 0x00 read with `csr_readdata`=0xFF → all 8 bits read back 1; no bit slips.
- **Back-to-back frames** with 4-cycle `nss` gap → both frames are decoded; `chip_select` drops between them.
